print_queue_tx: RTL and testbench

Buffered, parametrised successor to the printer-side transmit path. Accepts ASCII characters from the key decoder via a one-cycle rdy strobe, queues them in a FIFO, and serialises them as UART frames on tx toward the thermal printer. The decoder no longer stalls on every character; back-pressure is exposed as full. Sits between decoder and the GPIO pins in the top-level chip interface.

---
 rtl/print_pkg.sv | 24 ++
 rtl/char_fifo.sv | 75 +++++++
 rtl/print_queue_tx.sv | 189 ++++++++++++++++++
 tb/tb_print_queue_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/print_pkg.sv
// print_pkg: shared definitions for the printer transmit queue.
//   tx_state_t        transmit FSM states
//   ASCII_CR/ASCII_LF control characters the decoder commonly emits
//   DEFAULT_BAUD_DIV  50 MHz / 9600 baud
//   even_parity()     XOR reduction of one data byte
package print_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [7:0]  ASCII_CR         = 8'h0D;
    localparam logic [7:0]  ASCII_LF         = 8'h0A;
    localparam int unsigned DEFAULT_BAUD_DIV = 5208;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// char_fifo: synchronous FIFO of WIDTH-bit entries, DEPTH a power of two.
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push_i        write wdata_i at the next edge (ignored while full)
//   wdata_i       write data
//   pop_i         drop the head entry at the next edge (ignored while empty)
//   rdata_o       head entry, valid while !empty_o
//   full_o        DEPTH entries held
//   empty_o       no entries held
//   count_o       current occupancy
// full/empty are evaluated before the edge, so a push while full is dropped
// even if a pop happens in the same cycle.
module char_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/print_queue_tx.sv
// print_queue_tx: buffered UART transmitter feeding the thermal printer.
// Characters strobed in with rdy are queued in a char_fifo and sent as
// 8-bit LSB-first frames with STOP_BITS stop bits.
//   clk, rst   system clock, synchronous active-high reset
//   rdy        one-cycle strobe, enqueue ascii
//   ascii      character to enqueue
//   full       FIFO holds DEPTH entries
//   empty      FIFO holds no entries
//   count      FIFO occupancy
//   overflow   sticky, set when rdy arrives while full (cleared by rst)
//   done       one-cycle pulse on the STOP->IDLE transition
//   busy       transmitter not in IDLE
//   tx         registered serial output, idle high
//   gnd        constant 0
// Build option: define PRINT_QUEUE_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
module print_queue_tx
    import print_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic [7:0]                 ascii,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       done,
    output logic                       busy,
    output logic                       tx,
    output logic                       gnd
);

    localparam int unsigned BaudW = $clog2(BAUD_DIV);
    localparam logic [BaudW-1:0] BaudLoad = BaudW'(BAUD_DIV - 1);

    tx_state_t        state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic             pop;
    logic [7:0]       head;
    logic             bit_end;
    logic             last_stop;

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rdy),
        .wdata_i (ascii),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign bit_end   = (baud_q == '0);
    assign last_stop = (STOP_BITS == 1) || stop_q;

    // Sticky drop flag; full is the pre-edge value, matching the FIFO's drop.
    assign ovf_d = ovf_q | (rdy & full);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop     = 1'b0;

        // The down-counter counts within a bit; every bit boundary reloads it.
        if (state_q != IDLE && !bit_end) begin
            baud_d = baud_q - BaudW'(1);
        end

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = BaudLoad;
                    shift_d = head;
                    par_d   = even_parity(head);
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = BaudLoad;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = BaudLoad;
                    if (bit_q == 3'd7) begin
`ifdef PRINT_QUEUE_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    baud_d  = BaudLoad;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_d = 1'b1;
                    if (last_stop) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                        baud_d = BaudLoad;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            stop_q  <= 1'b0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign overflow = ovf_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;
    assign gnd      = 1'b0;

endmodule

// File: tb/tb_print_queue_tx.sv
module tb_print_queue_tx;

    localparam int unsigned BD   = 4;
    localparam int unsigned DEP  = 4;
    localparam int unsigned SB   = 1;
`ifdef PRINT_QUEUE_PARITY_EN
    localparam int unsigned PAR  = 1;
`else
    localparam int unsigned PAR  = 0;
`endif
    localparam int unsigned NBIT = 9 + SB + PAR;
    localparam int unsigned FL   = NBIT * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b0;
    logic [7:0] ascii = 8'h00;
    logic       full, empty, overflow, done, busy, tx, gnd;
    logic [2:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb[$];
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    print_queue_tx #(
        .BAUD_DIV  (BD),
        .DEPTH     (DEP),
        .STOP_BITS (SB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .ascii    (ascii),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .done     (done),
        .busy     (busy),
        .tx       (tx),
        .gnd      (gnd)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drives at the negedge (outputs only move on posedge), so the next
    // posedge samples the new inputs.
    task automatic strobe(input logic [7:0] c, input bit expect_accept);
        @(negedge clk);
        rdy   = 1'b1;
        ascii = c;
        if (expect_accept) sb.push_back(c);
    endtask

    task automatic idle_in();
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drained(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && empty === 1'b1 && done === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Frame monitor: decodes tx at mid-bit and checks against the scoreboard.
    initial begin : monitor
        logic       prev_tx;
        logic [7:0] data;
        logic       pbit;
        logic [7:0] exp_c;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev_tx === 1'b1 && tx === 1'b0) begin
                repeat (BD / 2) @(negedge clk);
                chk("mon_start_bit", {31'd0, tx}, 32'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (BD) @(negedge clk);
                    data[b] = tx;
                end
                pbit = 1'b0;
                if (PAR != 0) begin
                    repeat (BD) @(negedge clk);
                    pbit = tx;
                end
                for (int s = 0; s < int'(SB); s++) begin
                    repeat (BD) @(negedge clk);
                    chk("mon_stop_bit", {31'd0, tx}, 32'd1);
                end
                if (sb.size() == 0) begin
                    chk("mon_unexpected_frame", {24'd0, data}, 32'hFFFF_FFFF);
                end else begin
                    exp_c = sb.pop_front();
                    chk("mon_frame_data", {24'd0, data}, {24'd0, exp_c});
                    if (PAR != 0) begin
                        chk("mon_parity", {31'd0, pbit}, {31'd0, ^exp_c});
                    end
                end
            end
            prev_tx = tx;
        end
    end

    typedef struct {
        logic [7:0] c;
        logic [0:7] seq;   // data bits in transmit order
        logic       par;
    } vec_t;

    vec_t vecs [4];

    initial begin : main
        bit   ok;
        logic exp_tx;
        int   bidx;
        bit   quiet;

        vecs[0] = '{c: 8'h41, seq: 8'b10000010, par: 1'b0};
        vecs[1] = '{c: 8'h07, seq: 8'b11100000, par: 1'b1};
        vecs[2] = '{c: 8'h0D, seq: 8'b10110000, par: 1'b1};
        vecs[3] = '{c: 8'hA5, seq: 8'b10100101, par: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_gnd", {31'd0, gnd}, 32'd0);
        mon_en = 1'b1;

        // Table-driven single frames, checked cycle by cycle
        for (int v = 0; v < 4; v++) begin
            strobe(vecs[v].c, 1'b1);
            idle_in();
            chk("enq_count", {29'd0, count}, 32'd1);
            chk("enq_busy", {31'd0, busy}, 32'd0);
            for (int cyc = 0; cyc <= int'(FL); cyc++) begin
                @(negedge clk);
                if (cyc == int'(FL)) begin
                    chk("frame_done", {31'd0, done}, 32'd1);
                    chk("frame_end_busy", {31'd0, busy}, 32'd0);
                    chk("frame_end_tx", {31'd0, tx}, 32'd1);
                end else begin
                    bidx = cyc / int'(BD);
                    if (bidx == 0)                         exp_tx = 1'b0;
                    else if (bidx <= 8)                    exp_tx = vecs[v].seq[bidx-1];
                    else if (PAR != 0 && bidx == 9)        exp_tx = vecs[v].par;
                    else                                   exp_tx = 1'b1;
                    chk("frame_tx", {31'd0, tx}, {31'd0, exp_tx});
                    if (cyc == int'(FL) - 1) chk("frame_no_early_done", {31'd0, done}, 32'd0);
                    if (cyc == 0) chk("frame_count_popped", {29'd0, count}, 32'd0);
                end
            end
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
        end

        // Overflow: first char starts sending, then five strobes while busy
        strobe(8'h61, 1'b1);
        idle_in();
        @(negedge clk);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        strobe(8'h62, 1'b1);
        strobe(8'h63, 1'b1);
        strobe(8'h64, 1'b1);
        strobe(8'h65, 1'b1);
        strobe(8'h66, 1'b0);
        idle_in();
        chk("ovf_count", {29'd0, count}, 32'd4);
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        wait_drained(6 * (FL + 4), ok);
        chk("ovf_drain_timeout", {31'd0, ok}, 32'd1);
        chk("ovf_empty_after", {31'd0, empty}, 32'd1);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("ovf_sb_empty", sb.size(), 32'd0);

        // Back-to-back with push and pop in the same cycle at count=2
        strobe(8'h5A, 1'b1);
        idle_in();
        strobe(8'h48, 1'b1);
        strobe(8'h69, 1'b1);
        idle_in();
        chk("b2b_count2", {29'd0, count}, 32'd2);
        wait_done(FL + 8, ok);
        chk("b2b_done_seen", {31'd0, ok}, 32'd1);
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
        chk("b2b_idle_count", {29'd0, count}, 32'd2);
        // Push lands on the same edge that pops 'H'
        rdy   = 1'b1;
        ascii = 8'h21;
        sb.push_back(8'h21);
        idle_in();
        chk("pushpop_count", {29'd0, count}, 32'd2);
        chk("b2b_start_busy", {31'd0, busy}, 32'd1);
        chk("b2b_start_tx", {31'd0, tx}, 32'd0);
        wait_drained(4 * (FL + 4), ok);
        chk("b2b_drain_timeout", {31'd0, ok}, 32'd1);
        chk("b2b_sb_empty", sb.size(), 32'd0);

        // Mid-frame reset with two characters queued
        mon_en = 1'b0;
        strobe(8'h70, 1'b0);
        strobe(8'h71, 1'b0);
        strobe(8'h72, 1'b0);
        idle_in();
        // Frame cycle 2 at this point; advance to cycle 15
        repeat (13) @(negedge clk);
        chk("mrst_busy_before", {31'd0, busy}, 32'd1);
        chk("mrst_count_before", {29'd0, count}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_tx", {31'd0, tx}, 32'd1);
        chk("mrst_count", {29'd0, count}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_empty", {31'd0, empty}, 32'd1);
        chk("mrst_overflow", {31'd0, overflow}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < int'(2 * FL); i++) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("mrst_abandoned", {31'd0, quiet}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
